mem_access_ctrl: RTL

- Parametrised successor to the pipeline MEM-stage load/store formatting logic.
- Converts byte, halfword, word and (at DATA_W=64) doubleword load/store requests from the MEM stage into aligned, byte-enabled transactions on a variable-latency data-memory port.
- Sign- or zero-extends load data, detects misaligned accesses, and holds the pipeline via req_ready while a transaction is outstanding.
- Sits between the EX/MEM pipeline register and the DRAM.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_lane_align.sv | 65 ++++++
 rtl/mem_access_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the MEM-stage data-memory access controller.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store shift and byte enables, load extract/extend,
// and misalignment detection. Purely combinational.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]          size_i,
  input  logic                unsigned_i,
  input  logic [2:0]          addr_lo_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W-1:0]   rdata_i,
  output logic [DATA_W/8-1:0] be_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                misaligned_o
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);

  logic [OFF_W-1:0]  off;
  logic [OFF_W+2:0]  bit_sh;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] lane;
  int unsigned       nbits;
  logic              fill;

  assign off    = addr_lo_i[OFF_W-1:0];
  assign bit_sh = {off, 3'b000};

  always_comb begin
    be_o      = BE_W'(size_mask(size_i)) << off;
    lane_mask = '0;
    for (int unsigned i = 0; i < BE_W; i++) begin
      lane_mask[i*8 +: 8] = {8{be_o[i]}};
    end
    wdata_o = (wdata_i << bit_sh) & lane_mask;
  end

  always_comb begin
    lane  = rdata_i >> bit_sh;
    nbits = 32'd8 << size_i;
    case (size_i)
      SZ_B:    fill = ~unsigned_i & lane[7];
      SZ_H:    fill = ~unsigned_i & lane[15];
      SZ_W:    fill = ~unsigned_i & lane[31];
      default: fill = ~unsigned_i & lane[DATA_W-1];
    endcase
    rdata_o = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      rdata_o[i] = (i < nbits) ? lane[i] : fill;
    end
  end

  always_comb begin
    case (size_i)
      SZ_B:    misaligned_o = 1'b0;
      SZ_H:    misaligned_o = addr_lo_i[0];
      SZ_W:    misaligned_o = |addr_lo_i[1:0];
      default: misaligned_o = (DATA_W == 32) || (|addr_lo_i[2:0]);
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: latches one request, runs it on the
// variable-latency data-memory port and returns a one-cycle response.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                dm_req,
  input  logic                dm_gnt,
  output logic                dm_we,
  output logic [ADDR_W-1:0]   dm_addr,
  output logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_wdata,
  input  logic                dm_rvalid,
  input  logic [DATA_W-1:0]   dm_rdata
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic                uns_q, uns_d;
  logic                err_q, err_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [1:0]          al_size;
  logic [2:0]          al_addr;
  logic [BE_W-1:0]     al_be;
  logic [DATA_W-1:0]   al_wdata;
  logic [DATA_W-1:0]   al_rdata;
  logic                al_mis;

  // One aligner serves both phases: live request fields in IDLE for the
  // misalignment decision, latched fields afterwards for the transaction.
  assign al_size = (state_q == ST_IDLE) ? req_size     : size_q;
  assign al_addr = (state_q == ST_IDLE) ? req_addr[2:0] : addr_q[2:0];

  mem_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .size_i       (al_size),
    .unsigned_i   (uns_q),
    .addr_lo_i    (al_addr),
    .wdata_i      (wdata_q),
    .rdata_i      (dm_rdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .rdata_o      (al_rdata),
    .misaligned_o (al_mis)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    uns_d   = uns_q;
    err_d   = err_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = al_mis;
          state_d = al_mis ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (dm_gnt) state_d = we_q ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        if (dm_rvalid) begin
          rdata_d = al_rdata;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    dm_req     = (state_q == ST_REQ);
    dm_we      = dm_req & we_q;
    dm_addr    = dm_req ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    dm_be      = dm_req ? al_be    : '0;
    dm_wdata   = dm_req ? al_wdata : '0;
    resp_valid = (state_q == ST_DONE);
    resp_rdata = resp_valid ? rdata_q : '0;
    resp_err   = resp_valid & err_q;
  end

endmodule
